// File: rtl/act_znz_gen.sv
// act_znz_gen
//   Activation zero/nonzero bitmap generator with N:GROUP_SIZE pruning.
//   Takes a stream of activation beats (M elements each). Every GROUP_SIZE/M
//   consecutive beats form one group. For each group it:
//     - keeps at most LIM nonzero elements (LIM = 8 or 16, sampled on the
//       group's first beat), with lower beat / lower element index first,
//     - forwards every beat with pruned elements forced to zero (act channel),
//     - emits one nonzero bitmap per group plus an overflow flag (znz channel).
//   The act and znz outputs are one-entry registers. They drain
//   independently, and each can load and drain in the same cycle.
//
// Configuration macro:
//   ACT_ZNZ_PRUNE_EN  defined   : elements beyond LIM are pruned (zeroed).
//                     undefined : nothing is pruned. znz_ovf_o still flags
//                                 groups whose nonzero count exceeds LIM.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   group_nz_sel   in   0: limit 8, 1: limit 16 (sampled on beat 0)
//   act_din        in   M x DATA_W input beat, element i in act_din[i]
//   act_din_vld_i  in   input beat valid
//   act_din_rdy_o  out  input beat ready
//   act_dout       out  M x DATA_W pruned beat
//   act_dout_vld_o out  pruned beat valid
//   act_dout_rdy_i in   pruned beat ready
//   znz_dout       out  GROUP_SIZE bitmap, bit b*M+i = element i of beat b
//   znz_vld_o      out  bitmap valid
//   znz_rdy_i      in   bitmap ready
//   znz_ovf_o      out  raw nonzero count of the group exceeded LIM

module act_znz_gen #(
  parameter int M            = 8,
  parameter int DATA_W       = 8,
  parameter int GROUP_SIZE   = 32,
  parameter int GROUP_NZ_MAX = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         group_nz_sel,
  input  logic [M-1:0][DATA_W-1:0]     act_din,
  input  logic                         act_din_vld_i,
  output logic                         act_din_rdy_o,
  output logic [M-1:0][DATA_W-1:0]     act_dout,
  output logic                         act_dout_vld_o,
  input  logic                         act_dout_rdy_i,
  output logic [GROUP_SIZE-1:0]        znz_dout,
  output logic                         znz_vld_o,
  input  logic                         znz_rdy_i,
  output logic                         znz_ovf_o
);

  localparam int BEATS = GROUP_SIZE / M;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W = $clog2(GROUP_SIZE + 1);

  // Beat position is tracked as a down-counter of beats remaining after the
  // current one: BEATS-1 on the first beat, terminal count 0 on the last.
  localparam logic [BW-1:0]    FIRST_LEFT = BW'(BEATS - 1);
  localparam logic [CNT_W-1:0] LIM_HI     = CNT_W'(GROUP_NZ_MAX);
  localparam logic [CNT_W-1:0] LIM_LO     = CNT_W'(GROUP_NZ_MAX / 2);

  // State
  logic [BW-1:0]              beats_left_q, beats_left_d;
  logic [CNT_W-1:0]           nz_cnt_q,     nz_cnt_d;
  logic [CNT_W-1:0]           lim_q,        lim_d;
  logic [GROUP_SIZE-1:0]      znz_acc_q,    znz_acc_d;
  logic [M-1:0][DATA_W-1:0]   act_dout_q,   act_dout_d;
  logic                       act_vld_q,    act_vld_d;
  logic [GROUP_SIZE-1:0]      znz_q,        znz_d;
  logic                       znz_ovf_q,    znz_ovf_d;
  logic                       znz_vld_q,    znz_vld_d;

  // Datapath
  logic                       first_beat;
  logic                       last_beat;
  logic                       din_rdy;
  logic                       accept;
  logic [CNT_W-1:0]           lim_cur;
  logic [CNT_W-1:0]           cnt_run;
  logic [M-1:0]               keep_vec;
  logic [M-1:0][DATA_W-1:0]   act_pruned;
  logic                       ovf_new;
  logic [GROUP_SIZE-1:0]      znz_shift;

  assign first_beat = (beats_left_q == FIRST_LEFT);
  assign last_beat  = (beats_left_q == '0);

  // Ready depends only on the downstream readies, never on act_din_vld_i.
  // The last beat of a group also needs room in the bitmap register.
  assign din_rdy = !rst
                && (!act_vld_q || act_dout_rdy_i)
                && (!last_beat || !znz_vld_q || znz_rdy_i);
  assign accept  = act_din_vld_i && din_rdy;

  // Keep/prune decision. cnt_run is the raw nonzero count of the group so far.
  // While it is below LIM, the raw and kept counts are equal, so comparing
  // the raw count with LIM gives the kept-count rule.
  always_comb begin
    lim_cur    = first_beat ? (group_nz_sel ? LIM_HI : LIM_LO) : lim_q;
    cnt_run    = first_beat ? '0 : nz_cnt_q;
    keep_vec   = '0;
    act_pruned = '0;
    for (int i = 0; i < M; i++) begin
      if (act_din[i] != '0) begin
`ifdef ACT_ZNZ_PRUNE_EN
        keep_vec[i] = (cnt_run < lim_cur);
`else
        keep_vec[i] = 1'b1;
`endif
        cnt_run = cnt_run + CNT_W'(1);
      end
      act_pruned[i] = keep_vec[i] ? act_din[i] : '0;
    end
    // Pruning keeps the first LIM nonzeros. So "something was pruned" and
    // "raw count > LIM" are the same condition in both builds.
    ovf_new = (cnt_run > lim_cur);
  end

  // The bitmap is assembled by shifting each beat in at the top. After BEATS
  // shifts, beat 0 sits in the low M bits. The previous group's bits have all
  // been shifted out, so the accumulator needs no clear at group start.
  generate
    if (BEATS > 1) begin : g_multi_beat
      assign znz_shift = {keep_vec, znz_acc_q[GROUP_SIZE-1:M]};
    end else begin : g_single_beat
      assign znz_shift = keep_vec;
    end
  endgenerate

  always_comb begin
    beats_left_d = beats_left_q;
    nz_cnt_d     = nz_cnt_q;
    lim_d        = lim_q;
    znz_acc_d    = znz_acc_q;
    act_dout_d   = act_dout_q;
    act_vld_d    = act_vld_q;
    znz_d        = znz_q;
    znz_ovf_d    = znz_ovf_q;
    znz_vld_d    = znz_vld_q;

    if (accept) begin
      nz_cnt_d     = cnt_run;
      lim_d        = lim_cur;
      znz_acc_d    = znz_shift;
      beats_left_d = last_beat ? FIRST_LEFT : beats_left_q - BW'(1);
    end

    // Output registers: load wins over drain, so drain+load is bubble-free.
    if (accept) begin
      act_dout_d = act_pruned;
      act_vld_d  = 1'b1;
    end else if (act_dout_rdy_i) begin
      act_vld_d  = 1'b0;
    end

    if (accept && last_beat) begin
      znz_d     = znz_shift;
      znz_ovf_d = ovf_new;
      znz_vld_d = 1'b1;
    end else if (znz_rdy_i) begin
      znz_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_left_q <= FIRST_LEFT;
      nz_cnt_q     <= '0;
      lim_q        <= LIM_LO;
      znz_acc_q    <= '0;
      act_dout_q   <= '0;
      act_vld_q    <= 1'b0;
      znz_q        <= '0;
      znz_ovf_q    <= 1'b0;
      znz_vld_q    <= 1'b0;
    end else begin
      beats_left_q <= beats_left_d;
      nz_cnt_q     <= nz_cnt_d;
      lim_q        <= lim_d;
      znz_acc_q    <= znz_acc_d;
      act_dout_q   <= act_dout_d;
      act_vld_q    <= act_vld_d;
      znz_q        <= znz_d;
      znz_ovf_q    <= znz_ovf_d;
      znz_vld_q    <= znz_vld_d;
    end
  end

  assign act_din_rdy_o  = din_rdy;
  assign act_dout       = act_dout_q;
  assign act_dout_vld_o = act_vld_q;
  assign znz_dout       = znz_q;
  assign znz_ovf_o      = znz_ovf_q;
  assign znz_vld_o      = znz_vld_q;

endmodule
